// File: rtl/dtc_pkg.sv
// rtl/dtc_pkg.sv - shared frame kinds and header constants for the DTC transmit path
package dtc_pkg;

    // Frame kind handed from the scheduler to the serial transmitter.
    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_EVENT  = 2'd1,
        KIND_REPLY  = 2'd2,
        KIND_STATUS = 2'd3
    } dtc_kind_t;

    // Frame header words emitted by the transmitter for each kind.
    localparam logic [15:0] HDR_EVENT  = 16'h5C5C;
    localparam logic [15:0] HDR_REPLY  = 16'hF7F7;
    localparam logic [15:0] HDR_STATUS = 16'hDCDC;
    localparam logic [15:0] HDR_SYNC   = 16'hBC50;

endpackage

// File: rtl/dtc_req_latch.sv
// rtl/dtc_req_latch.sv - one-deep pending flag for a pulsed request with sticky overflow
//
// Ports:
//   dtc_clk  in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   1-cycle request pulse
//   clr      in   grant: drop the pending request
//   pend     out  request waiting to be granted
//   ovf      out  sticky: a request arrived while one was already pending
module dtc_req_latch (
    input  logic dtc_clk,
    input  logic rst_n,
    input  logic req,
    input  logic clr,
    output logic pend,
    output logic ovf
);

    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            // A new pulse wins over a same-cycle grant: the flag re-arms for
            // the new request. Hitting a set flag means one request is lost.
            if (req) begin
                pend <= 1'b1;
                if (pend) begin
                    ovf <= 1'b1;
                end
            end else if (clr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dtc_tx_sched.sv
// rtl/dtc_tx_sched.sv - frame scheduler in front of the DTC serial transmitter
//
// Ports:
//   dtc_clk, rst_n               clock and asynchronous active-low reset
//   rdo_req                      event readout trigger pulse
//   rd_req, rd_addr              register read request pulse and its address
//   rd_data, rd_data_vld         register read data and its valid pulse
//   st_req, status               status request pulse and live status word
//   tx_start, tx_kind            frame start strobe and kind to the transmitter
//   tx_addr, tx_data, tx_status  frame payload held for the frame
//   tx_done                      transmitter finished the current frame
//   busy                         a frame is granted and not yet finished
//   ovf                          sticky {st,rd,rdo} request overflow
//   rd_timeout                   sticky: a reply went out carrying ERR_DATA
module dtc_tx_sched
    import dtc_pkg::*;
#(
    parameter int          MAX_EVT_BURST = 4,
    parameter int          RD_TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA      = 32'hDEADBEEF
) (
    input  logic        dtc_clk,
    input  logic        rst_n,
    input  logic        rdo_req,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    input  logic        rd_data_vld,
    input  logic        st_req,
    input  logic [15:0] status,
    output logic        tx_start,
    output dtc_kind_t   tx_kind,
    output logic [31:0] tx_addr,
    output logic [31:0] tx_data,
    output logic [15:0] tx_status,
    input  logic        tx_done,
    output logic        busy,
    output logic [2:0]  ovf,
    output logic        rd_timeout
);

    localparam int TO_W = $clog2(RD_TIMEOUT + 1);
    localparam int BU_W = $clog2(MAX_EVT_BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WAIT_DATA,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t           state;
    logic [TO_W-1:0]  to_cnt;
    logic [BU_W-1:0]  burst_cnt;
    logic             data_got;
    logic [31:0]      pend_addr;

    logic pend_rdo, pend_rd, pend_st;
    logic gnt_ev, gnt_rd, gnt_st;
    logic burst_hold;

    dtc_req_latch u_rdo_latch (
        .dtc_clk (dtc_clk),
        .rst_n   (rst_n),
        .req     (rdo_req),
        .clr     (gnt_ev),
        .pend    (pend_rdo),
        .ovf     (ovf[0])
    );

    dtc_req_latch u_rd_latch (
        .dtc_clk (dtc_clk),
        .rst_n   (rst_n),
        .req     (rd_req),
        .clr     (gnt_rd),
        .pend    (pend_rd),
        .ovf     (ovf[1])
    );

    dtc_req_latch u_st_latch (
        .dtc_clk (dtc_clk),
        .rst_n   (rst_n),
        .req     (st_req),
        .clr     (gnt_st),
        .pend    (pend_st),
        .ovf     (ovf[2])
    );

    // Address of the pending read. A second read while one is pending is
    // dropped, so only accept a new address when the slot is free or being
    // granted this very cycle.
    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_addr <= '0;
        end else if (rd_req && (!pend_rd || gnt_rd)) begin
            pend_addr <= rd_addr;
        end
    end

    // Events normally win; after MAX_EVT_BURST back-to-back event grants with
    // a reply or status waiting, the lower kinds get one turn.
    always_comb begin
        gnt_ev     = 1'b0;
        gnt_rd     = 1'b0;
        gnt_st     = 1'b0;
        burst_hold = (burst_cnt == BU_W'(MAX_EVT_BURST)) && (pend_rd || pend_st);
        if (state == S_ARB) begin
            if (pend_rdo && !burst_hold) begin
                gnt_ev = 1'b1;
            end else if (pend_rd) begin
                gnt_rd = 1'b1;
            end else if (pend_st) begin
                gnt_st = 1'b1;
            end
        end
    end

    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tx_start   <= 1'b0;
            tx_kind    <= KIND_NONE;
            tx_addr    <= '0;
            tx_data    <= '0;
            tx_status  <= '0;
            busy       <= 1'b0;
            rd_timeout <= 1'b0;
            burst_cnt  <= '0;
            to_cnt     <= '0;
            data_got   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pend_rdo || pend_rd || pend_st) begin
                        state <= S_ARB;
                    end
                end

                S_ARB: begin
                    if (gnt_ev) begin
                        tx_kind  <= KIND_EVENT;
                        busy     <= 1'b1;
                        tx_start <= 1'b1;
                        state    <= S_ISSUE;
                        // The burst only counts while something else waits.
                        if (pend_rd || pend_st) begin
                            burst_cnt <= burst_cnt + BU_W'(1);
                        end else begin
                            burst_cnt <= '0;
                        end
                    end else if (gnt_rd) begin
                        tx_kind   <= KIND_REPLY;
                        tx_addr   <= pend_addr;
                        busy      <= 1'b1;
                        burst_cnt <= '0;
                        to_cnt    <= '0;
                        data_got  <= 1'b0;
                        state     <= S_WAIT_DATA;
                    end else if (gnt_st) begin
                        tx_kind   <= KIND_STATUS;
                        tx_status <= status;
                        busy      <= 1'b1;
                        tx_start  <= 1'b1;
                        burst_cnt <= '0;
                        state     <= S_ISSUE;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_WAIT_DATA: begin
                    // Data is captured one cycle before the start strobe so
                    // the payload is already settled when tx_start rises.
                    if (data_got) begin
                        tx_start <= 1'b1;
                        state    <= S_ISSUE;
                    end else if (rd_data_vld) begin
                        tx_data  <= rd_data;
                        data_got <= 1'b1;
                    end else if (to_cnt == TO_W'(RD_TIMEOUT)) begin
                        tx_data    <= ERR_DATA;
                        rd_timeout <= 1'b1;
                        tx_start   <= 1'b1;
                        state      <= S_ISSUE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_ISSUE: begin
                    tx_start <= 1'b0;
                    to_cnt   <= '0;
                    data_got <= 1'b0;
                    state    <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    if (tx_done) begin
                        busy    <= 1'b0;
                        tx_kind <= KIND_NONE;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_tx_sched.sv
// tb/tb_dtc_tx_sched.sv - self-checking bench for dtc_tx_sched
module tb_dtc_tx_sched;
    import dtc_pkg::*;

    localparam int          RD_TIMEOUT = 255;
    localparam int          MAX_BURST  = 4;
    localparam logic [31:0] ERR        = 32'hDEADBEEF;

    logic        dtc_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdo_req = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [31:0] rd_data = '0;
    logic        rd_data_vld = 1'b0;
    logic        st_req = 1'b0;
    logic [15:0] status = '0;
    logic        tx_done = 1'b0;
    logic        tx_start;
    dtc_kind_t   tx_kind;
    logic [31:0] tx_addr;
    logic [31:0] tx_data;
    logic [15:0] tx_status;
    logic        busy;
    logic [2:0]  ovf;
    logic        rd_timeout;

    dtc_tx_sched #(
        .MAX_EVT_BURST (MAX_BURST),
        .RD_TIMEOUT    (RD_TIMEOUT),
        .ERR_DATA      (ERR)
    ) dut (
        .dtc_clk     (dtc_clk),
        .rst_n       (rst_n),
        .rdo_req     (rdo_req),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld),
        .st_req      (st_req),
        .status      (status),
        .tx_start    (tx_start),
        .tx_kind     (tx_kind),
        .tx_addr     (tx_addr),
        .tx_data     (tx_data),
        .tx_status   (tx_status),
        .tx_done     (tx_done),
        .busy        (busy),
        .ovf         (ovf),
        .rd_timeout  (rd_timeout)
    );

    always #5 dtc_clk = ~dtc_clk;

    int cyc = 0;
    always @(posedge dtc_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge dtc_clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        rdo_req = 0; rd_req = 0; st_req = 0; rd_data_vld = 0; tx_done = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_start(input string name, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (tx_start) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no tx_start within %0d cycles", name, budget);
        end
    endtask

    task automatic finish_frame();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic pulse_rdo();
        rdo_req = 1'b1;
        tick();
        rdo_req = 1'b0;
    endtask

    typedef struct {
        dtc_kind_t   kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          vld_dly;
        logic [15:0] st;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    // Random-phase reference model state.
    logic [2:0]  m_pend, n_pend, clr, m_ovf, reqs;
    logic [31:0] m_paddr, m_addr, m_data;
    logic [15:0] m_status;
    int          m_burst;
    logic        m_busy, arb_now, waiting, in_frame, others;
    dtc_kind_t   m_kind;
    int          start_at, vld_at, done_at;

    initial begin
        int n, at, got, nstart;
        dtc_kind_t exp_k[6];

        vecs[0] = '{KIND_EVENT,  32'h0,          32'h0,          0, 16'h0000, 3};
        vecs[1] = '{KIND_STATUS, 32'h0,          32'h0,          0, 16'hA55A, 3};
        vecs[2] = '{KIND_REPLY,  32'h0000_0104,  32'h1234_5678,  3, 16'h0000, 5};
        vecs[3] = '{KIND_STATUS, 32'h0,          32'h0,          0, 16'h0001, 3};
        vecs[4] = '{KIND_REPLY,  32'hFFFF_FFFC,  32'h0000_0000,  4, 16'h0000, 6};
        vecs[5] = '{KIND_REPLY,  32'h8000_0000,  32'hCAFE_F00D,  9, 16'h0000, 11};
        vecs[6] = '{KIND_EVENT,  32'h0,          32'h0,          0, 16'h0000, 3};

        apply_reset();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_kind", tx_kind, KIND_NONE);
        chk("rst_addr", tx_addr, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_status", tx_status, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_rd_timeout", rd_timeout, 0);

        // Event latency and busy release.
        n = cyc;
        pulse_rdo();
        chk("t1_start_n1", tx_start, 0);
        tick();
        chk("t1_start_n2", tx_start, 0);
        tick();
        chk("t1_start_n3", tx_start, 1);
        chk("t1_kind", tx_kind, KIND_EVENT);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_start_n4", tx_start, 0);
        while (cyc < n + 50) tick();
        chk("t1_kind_hold", tx_kind, KIND_EVENT);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t1_busy_after_done", busy, 0);
        chk("t1_kind_after_done", tx_kind, KIND_NONE);

        // Table of single requests.
        foreach (vecs[v]) begin
            tick();
            n = cyc;
            status = vecs[v].st;
            rd_addr = vecs[v].addr;
            rdo_req = (vecs[v].kind == KIND_EVENT);
            rd_req  = (vecs[v].kind == KIND_REPLY);
            st_req  = (vecs[v].kind == KIND_STATUS);
            tick();
            rdo_req = 0; rd_req = 0; st_req = 0;
            rd_addr = 32'h5555_5555;
            got = -1;
            for (int i = 0; i < 30 && got < 0; i++) begin
                rd_data_vld = 1'b0;
                if (vecs[v].kind == KIND_REPLY && cyc == n + vecs[v].vld_dly) begin
                    rd_data_vld = 1'b1;
                    rd_data = vecs[v].data;
                end
                if (tx_start) got = cyc;
                else tick();
            end
            rd_data_vld = 1'b0;
            rd_data = 32'h0BAD_0BAD;
            chk($sformatf("vec%0d_latency", v), got - n, vecs[v].exp_lat);
            chk($sformatf("vec%0d_kind", v), tx_kind, vecs[v].kind);
            if (vecs[v].kind == KIND_REPLY) begin
                chk($sformatf("vec%0d_addr", v), tx_addr, vecs[v].addr);
                chk($sformatf("vec%0d_data", v), tx_data, vecs[v].data);
            end
            if (vecs[v].kind == KIND_STATUS) begin
                chk($sformatf("vec%0d_status", v), tx_status, vecs[v].st);
            end
            status = 16'hFFFF;
            tick();
            chk($sformatf("vec%0d_strobe_1cyc", v), tx_start, 0);
            tick(); tick();
            chk($sformatf("vec%0d_hold", v),
                {tx_kind, tx_addr, tx_data},
                {vecs[v].kind,
                 (vecs[v].kind == KIND_REPLY) ? vecs[v].addr : tx_addr,
                 (vecs[v].kind == KIND_REPLY) ? vecs[v].data : tx_data});
            if (vecs[v].kind == KIND_STATUS) begin
                chk($sformatf("vec%0d_status_hold", v), tx_status, vecs[v].st);
            end
            finish_frame();
            chk($sformatf("vec%0d_busy_end", v), busy, 0);
        end
        chk("table_ovf", ovf, 0);

        // Read with no data: timeout reply.
        apply_reset();
        n = cyc;
        rd_req = 1'b1; rd_addr = 32'h0000_0200;
        tick();
        rd_req = 1'b0;
        wait_start("t3_start", RD_TIMEOUT + 30, at);
        chk("t3_latency_window",
            ((at - n) >= RD_TIMEOUT + 2) && ((at - n) <= RD_TIMEOUT + 6), 1);
        chk("t3_kind", tx_kind, KIND_REPLY);
        chk("t3_data", tx_data, ERR);
        chk("t3_addr", tx_addr, 32'h0000_0200);
        chk("t3_rd_timeout", rd_timeout, 1);
        finish_frame();
        chk("t3_rd_timeout_sticky", rd_timeout, 1);

        // Event burst limit with a status waiting.
        apply_reset();
        status = 16'h7E7E;
        rdo_req = 1'b1; st_req = 1'b1;
        tick();
        rdo_req = 1'b0; st_req = 1'b0;
        exp_k = '{KIND_EVENT, KIND_EVENT, KIND_EVENT, KIND_EVENT, KIND_STATUS, KIND_EVENT};
        for (int i = 0; i < 6; i++) begin
            wait_start($sformatf("t4_start%0d", i), 40, at);
            chk($sformatf("t4_kind%0d", i), tx_kind, exp_k[i]);
            tick();
            if (i < 4) pulse_rdo();
            finish_frame();
        end
        chk("t4_status_word", tx_status, 16'h7E7E);
        chk("t4_ovf", ovf, 0);
        nstart = 0;
        for (int i = 0; i < 15; i++) begin
            if (tx_start) nstart++;
            tick();
        end
        chk("t4_no_extra", nstart, 0);

        // Two event requests during one event frame.
        apply_reset();
        pulse_rdo();
        wait_start("t5_start0", 10, at);
        tick();
        pulse_rdo();
        tick();
        pulse_rdo();
        tick();
        chk("t5_ovf", ovf, 3'b001);
        finish_frame();
        nstart = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_start) begin
                nstart++;
                chk("t5_extra_kind", tx_kind, KIND_EVENT);
                tick();
                tx_done = 1'b1;
                tick();
                tx_done = 1'b0;
            end else begin
                tick();
            end
        end
        chk("t5_extra_frames", nstart, 1);

        // Reset mid-frame with requests pending.
        apply_reset();
        pulse_rdo();
        wait_start("t6_start", 10, at);
        tick();
        rd_req = 1'b1; st_req = 1'b1; rd_addr = 32'h0000_0300;
        tick();
        rd_req = 1'b0; st_req = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_kind", tx_kind, KIND_NONE);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_start", tx_start, 0);
        chk("t6_async_addr", tx_addr, 0);
        tick();
        rst_n = 1'b1;
        nstart = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_start || busy) nstart++;
            tick();
        end
        chk("t6_no_activity", nstart, 0);

        // Randomized traffic against the reference model.
        apply_reset();
        m_pend = 0; m_ovf = 0; m_paddr = 0; m_addr = 0; m_data = 0; m_status = 0;
        m_burst = 0; m_busy = 0; arb_now = 0; waiting = 0; in_frame = 0;
        m_kind = KIND_NONE; start_at = -1; vld_at = -1; done_at = -1;
        for (int k = 0; k < 3000; k++) begin
            int c;
            logic r_rdo, r_rd, r_st, r_vld, r_done;
            logic [31:0] r_addr, r_data;
            logic [15:0] r_stat;
            c = cyc;
            chk("rnd_tx_start", tx_start, (c == start_at));
            chk("rnd_busy", busy, m_busy);
            chk("rnd_kind", tx_kind, m_kind);
            chk("rnd_addr", tx_addr, m_addr);
            chk("rnd_data", tx_data, m_data);
            chk("rnd_status", tx_status, m_status);
            chk("rnd_ovf", ovf, m_ovf);
            chk("rnd_rd_timeout", rd_timeout, 0);

            r_rdo  = ($urandom_range(0, 9) == 0);
            r_rd   = ($urandom_range(0, 11) == 0);
            r_st   = ($urandom_range(0, 13) == 0);
            r_addr = $urandom;
            r_data = $urandom;
            r_stat = 16'($urandom);
            r_vld  = waiting ? (c == vld_at) : ($urandom_range(0, 19) == 0);
            r_done = in_frame ? (c == done_at) : (!m_busy && $urandom_range(0, 19) == 0);
            rdo_req = r_rdo; rd_req = r_rd; st_req = r_st; rd_addr = r_addr;
            rd_data = r_data; rd_data_vld = r_vld; status = r_stat; tx_done = r_done;

            clr = 3'b000;
            if (arb_now) begin
                others = m_pend[1] | m_pend[2];
                arb_now = 0;
                m_busy = 1;
                if (m_pend[0] && !(m_burst == MAX_BURST && others)) begin
                    m_kind = KIND_EVENT; clr[0] = 1;
                    m_burst = others ? m_burst + 1 : 0;
                    start_at = c + 1;
                end else if (m_pend[1]) begin
                    m_kind = KIND_REPLY; clr[1] = 1; m_burst = 0;
                    m_addr = m_paddr; waiting = 1;
                    vld_at = c + 1 + int'($urandom_range(0, 5));
                end else begin
                    m_kind = KIND_STATUS; clr[2] = 1; m_burst = 0;
                    m_status = r_stat; start_at = c + 1;
                end
            end else if (!m_busy && m_pend != 0) begin
                arb_now = 1;
            end
            reqs = {r_st, r_rd, r_rdo};
            n_pend = m_pend;
            for (int j = 0; j < 3; j++) begin
                if (reqs[j]) begin
                    if (m_pend[j]) m_ovf[j] = 1'b1;
                    n_pend[j] = 1'b1;
                end else if (clr[j]) begin
                    n_pend[j] = 1'b0;
                end
            end
            if (r_rd && (!m_pend[1] || clr[1])) m_paddr = r_addr;
            m_pend = n_pend;
            if (waiting && c == vld_at) begin
                m_data = r_data;
                start_at = c + 2;
                waiting = 0;
            end
            if (c == start_at) begin
                in_frame = 1;
                done_at = c + int'($urandom_range(1, 8));
            end else if (in_frame && c == done_at) begin
                in_frame = 0;
                m_busy = 0;
                m_kind = KIND_NONE;
            end
            tick();
        end
        rdo_req = 0; rd_req = 0; st_req = 0; rd_data_vld = 0; tx_done = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
